// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared definitions for the registered, parametrised NZCV ALU.   |
// |            Op-code encodings, flag bit positions, FSM state encoding and a |
// |            helper that packs the four flags in {N,Z,C,V} order.            |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

   // Op codes; the low two bits of ADD/SUB/AND/OR line up with the 2-bit ALU.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   // Flag bit positions inside ALUFlags.
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // Control FSM encoding.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   function automatic logic [3:0] make_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f        = '0;
      f[FLG_N] = n;
      f[FLG_Z] = z;
      f[FLG_C] = c;
      f[FLG_V] = v;
      return f;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mul_iter                                                    |
// | Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle.   |
// |            Produces the low WIDTH bits of A*B (same for signed/unsigned).  |
// | Ports    : clk, rst_n      - clock, async active-low reset                 |
// |            start           - load A/B and begin WIDTH iterations          |
// |            A, B            - operands (sampled on start)                   |
// |            busy            - an operation is in flight                     |
// |            done            - product is final (held one cycle, then idle)  |
// |            product         - low WIDTH bits of A*B                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   import alu_pkg::*;

   localparam int             CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] prod_q,   prod_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             busy_q,   busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = A;
         mplier_d = B;
         prod_d   = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (cnt_q == CNT_LAST) begin
            // Product was presented as done this cycle; drop back to idle.
            busy_d = 1'b0;
         end else begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            // Multiplicand bits shifted past the top only affect the
            // discarded high half, so a WIDTH-bit register is enough.
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q & (cnt_q == CNT_LAST);
   assign product = prod_q;

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_param                                                   |
// | Purpose  : Registered, parametrised NZCV ALU with valid/ready handshakes.  |
// |            ADD/SUB/AND/OR/XOR/SLL/SRL complete in one cycle; MUL runs on   |
// |            an iterative multiplier and takes WIDTH+1 cycles.               |
// | Ports    : clk, rst_n           - clock, async active-low reset            |
// |            in_valid/in_ready    - operand handshake                        |
// |            A, B, ALUOp          - operands and op code                     |
// |            out_valid/out_ready  - result handshake                         |
// |            Result, ALUFlags     - registered result and {N,Z,C,V}          |
// |            op_err               - result came from an illegal op           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_seq_param #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags,
   output logic             op_err
);
   import alu_pkg::*;

   localparam int   SHW       = $clog2(WIDTH);
   localparam logic MUL_LEGAL = (MUL_EN != 0);

   // ---------------------------------------------------------------- control
   logic [0:0]       state_q, state_d;
   logic             accept;
   logic             op_is_mul;
   logic             mul_start;
   logic             single_fire;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign op_is_mul   = (ALUOp == OP_MUL);
   assign mul_start   = accept & op_is_mul & MUL_LEGAL;
   // Everything except a legal MUL (including an illegal MUL) answers in
   // one cycle.
   assign single_fire = accept & ~(op_is_mul & MUL_LEGAL);

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mul_start) begin
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            // A multiplier that is not busy here can only mean it lost its
            // operation; return to IDLE instead of waiting forever.
            if (mul_done || !mul_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready = (state_q == ST_IDLE) & (~out_valid | out_ready);
      accept   = in_valid & in_ready;
   end

   // -------------------------------------------------------------- multiplier
   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(
            .WIDTH (WIDTH)
         ) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mul_start),
            .A       (A),
            .B       (B),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_busy    = 1'b0;
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // ------------------------------------------------- single-cycle datapath
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   add_full;
   logic             add_v;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sll_full;
   logic [WIDTH:0]   srl_full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;

   always_comb begin
      is_sub   = (ALUOp == OP_SUB);
      b_eff    = is_sub ? ~B : B;
      add_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      // Overflow: both adder inputs share a sign that the sum does not.
      add_v    = (A[WIDTH-1] == b_eff[WIDTH-1]) & (add_full[WIDTH-1] != A[WIDTH-1]);
      shamt    = B[SHW-1:0];
      // One guard bit on each side catches the last bit shifted out; it
      // stays 0 for a zero amount.
      sll_full = {1'b0, A} << shamt;
      srl_full = {A, 1'b0} >> shamt;

      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (ALUOp)
         OP_ADD, OP_SUB: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = add_v;
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_SLL: begin
            alu_res = sll_full[WIDTH-1:0];
            alu_c   = sll_full[WIDTH];
         end
         OP_SRL: begin
            alu_res = srl_full[WIDTH:1];
            alu_c   = srl_full[0];
         end
         default: begin
            // Only reached for MUL when the multiplier is absent: a zero
            // result gives the required 4'b0100 flags.
            alu_err = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------- output register
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic [3:0]       flags_q,     flags_d;
   logic             op_err_q,    op_err_d;

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      op_err_d    = op_err_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (single_fire) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         flags_d     = make_flags(alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v);
         op_err_d    = alu_err;
      end else if (state_q == ST_MUL && mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_product;
         flags_d     = make_flags(mul_product[WIDTH-1], ~|mul_product, 1'b0, 1'b0);
         op_err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         op_err_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         op_err_q    <= op_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign ALUFlags  = flags_q;
   assign op_err    = op_err_q;

endmodule : alu_seq_param
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq_param                                                |
// | Purpose  : Self-checking bench for alu_seq_param: directed vector tables,  |
// |            multi-cycle MUL / back-pressure / reset sequences, and a random |
// |            stream scored against a behavioural model.                     |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_seq_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance with multiplier
   logic        in_valid, in_ready, out_valid, out_ready, op_err;
   logic [31:0] a, b, result;
   logic [2:0]  op;
   logic [3:0]  flags;

   // 8-bit instance without multiplier
   logic       e8_in_valid, e8_in_ready, e8_out_valid, e8_out_ready, e8_op_err;
   logic [7:0] e8_a, e8_b, e8_result;
   logic [2:0] e8_op;
   logic [3:0] e8_flags;

   alu_seq_param #(.WIDTH(32), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .ALUOp(op), .out_valid(out_valid), .out_ready(out_ready),
      .Result(result), .ALUFlags(flags), .op_err(op_err)
   );

   alu_seq_param #(.WIDTH(8), .MUL_EN(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(e8_in_valid), .in_ready(e8_in_ready),
      .A(e8_a), .B(e8_b), .ALUOp(e8_op), .out_valid(e8_out_valid),
      .out_ready(e8_out_ready), .Result(e8_result), .ALUFlags(e8_flags),
      .op_err(e8_op_err)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: arithmetic on wide integers, no gate-level view.
   typedef struct packed {
      logic [63:0] res;
      logic [3:0]  flg;
      logic        err;
   } exp_t;

   function automatic exp_t model(input int w, input bit mul_en, input logic [2:0] opc,
                                  input logic [63:0] ai, input logic [63:0] bi);
      exp_t        e;
      logic [63:0] mask, x, y, full;
      longint      sx, sy, sr, smax, smin;
      int          amt;
      logic        c, v;
      mask = (64'd1 << w) - 64'd1;
      x    = ai & mask;
      y    = bi & mask;
      sx   = longint'(x);
      sy   = longint'(y);
      if (x[w-1]) sx = sx - (longint'(1) <<< w);
      if (y[w-1]) sy = sy - (longint'(1) <<< w);
      smax = (longint'(1) <<< (w - 1)) - 1;
      smin = -(longint'(1) <<< (w - 1));
      amt  = int'(y % 64'(w));
      c    = 1'b0;
      v    = 1'b0;
      e    = '0;
      case (opc)
         3'd0: begin
            full = x + y;
            c  = full[w];
            sr = sx + sy;
            v  = (sr > smax) || (sr < smin);
         end
         3'd1: begin
            full = x + ((~y) & mask) + 64'd1;
            c  = full[w];
            sr = sx - sy;
            v  = (sr > smax) || (sr < smin);
         end
         3'd2: full = x & y;
         3'd3: full = x | y;
         3'd4: full = x ^ y;
         3'd5: begin
            full = x << amt;
            c    = (amt == 0) ? 1'b0 : full[w];
         end
         3'd6: begin
            full = x >> amt;
            c    = (amt == 0) ? 1'b0 : x[amt-1];
         end
         default: begin
            if (mul_en) full = x * y;
            else begin
               full  = 64'd0;
               e.err = 1'b1;
            end
         end
      endcase
      e.res = full & mask;
      e.flg = {e.res[w-1], (e.res == 64'd0), c, v};
      return e;
   endfunction

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a, b, res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a, b, res;
      logic [3:0] flg;
      logic       err;
   } vec8_t;

   vec_t  tbl [14];
   vec8_t tbl8[8];
   exp_t  q[$];
   exp_t  e;
   int    bad, sent, got, cyc;
   bit    acc;
   localparam int NRAND = 300;

   initial begin
      tbl[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
      tbl[1]  = '{3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
      tbl[2]  = '{3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100};
      tbl[3]  = '{3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b1000};
      tbl[4]  = '{3'd4, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0100};
      tbl[5]  = '{3'd5, 32'h80000001, 32'h00000001, 32'h00000002, 4'b0010};
      tbl[6]  = '{3'd6, 32'h80000000, 32'h00000000, 32'h80000000, 4'b1000};
      tbl[7]  = '{3'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000};
      tbl[8]  = '{3'd6, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
      tbl[9]  = '{3'd6, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010};
      tbl[10] = '{3'd5, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000};
      tbl[11] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
      tbl[12] = '{3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
      tbl[13] = '{3'd4, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 4'b1000};

      tbl8[0] = '{3'd7, 8'h03, 8'h05, 8'h00, 4'b0100, 1'b1};
      tbl8[1] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0};
      tbl8[2] = '{3'd5, 8'h81, 8'h01, 8'h02, 4'b0010, 1'b0};
      tbl8[3] = '{3'd6, 8'h03, 8'h09, 8'h01, 4'b0010, 1'b0};
      tbl8[4] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0};
      tbl8[5] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0};
      tbl8[6] = '{3'd4, 8'h5A, 8'hFF, 8'hA5, 4'b1000, 1'b0};
      tbl8[7] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 4'b0100, 1'b1};

      in_valid = 0; out_ready = 1; a = '0; b = '0; op = '0;
      e8_in_valid = 0; e8_out_ready = 1; e8_a = '0; e8_b = '0; e8_op = '0;

      // Reset values
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags_err", 64'({flags, op_err}), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back single-cycle stream, one result per cycle
      for (int i = 0; i < 14; i++) begin
         op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; in_valid = 1;
         #1;
         chk($sformatf("stream_in_ready[%0d]", i), 64'(in_ready), 64'd1);
         tick();
         chk($sformatf("stream[%0d]", i), 64'({out_valid, result, flags, op_err}),
             64'({1'b1, tbl[i].res, tbl[i].flg, 1'b0}));
      end
      in_valid = 0;
      tick();
      chk("stream_end_valid", 64'(out_valid), 64'd0);

      // MUL: WIDTH+1 cycles, in_ready low throughout
      op = 3'd7; a = 32'h0000FFFF; b = 32'h00010001; in_valid = 1;
      #1;
      chk("mul_accept_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 0;
      bad = 0;
      for (int i = 0; i < 33; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
         tick();
      end
      chk("mul_busy_cycles", 64'(bad), 64'd0);
      chk("mul_result", 64'({out_valid, result, flags, op_err}),
          64'({1'b1, 32'hFFFFFFFF, 4'b1000, 1'b0}));

      // Back-pressure: hold result, refuse new op, then transfer + accept together
      out_ready = 0; op = 3'd0; a = 32'd10; b = 32'd20; in_valid = 1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (in_ready !== 1'b0) bad++;
         tick();
         if (out_valid !== 1'b1 || result !== 32'hFFFFFFFF || flags !== 4'b1000) bad++;
      end
      chk("hold_stable", 64'(bad), 64'd0);
      out_ready = 1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 0;
      chk("release_result", 64'({out_valid, result, flags}), 64'({1'b1, 32'd30, 4'b0000}));
      tick();
      chk("release_clear", 64'(out_valid), 64'd0);

      // Asynchronous reset 10 cycles into a MUL
      op = 3'd1; a = 32'd1; b = 32'd2; in_valid = 1;
      tick();
      chk("pre_rst_sub", 64'({result, flags}), 64'({32'hFFFFFFFF, 4'b1000}));
      op = 3'd7; a = 32'd3; b = 32'd5;
      tick();
      in_valid = 0;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", 64'({out_valid, result, flags, op_err}), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      chk("rst_release_ready", 64'(in_ready), 64'd1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) bad++;
         tick();
      end
      chk("mul_discarded", 64'(bad), 64'd0);
      op = 3'd0; a = 32'd1; b = 32'd2; in_valid = 1;
      tick();
      in_valid = 0;
      chk("add_after_rst", 64'({out_valid, result, flags}), 64'({1'b1, 32'd3, 4'b0000}));

      // 8-bit instance, multiplier absent
      for (int i = 0; i < 8; i++) begin
         e8_op = tbl8[i].op; e8_a = tbl8[i].a; e8_b = tbl8[i].b; e8_in_valid = 1;
         #1;
         chk($sformatf("w8_in_ready[%0d]", i), 64'(e8_in_ready), 64'd1);
         tick();
         chk($sformatf("w8[%0d]", i), 64'({e8_out_valid, e8_result, e8_flags, e8_op_err}),
             64'({1'b1, tbl8[i].res, tbl8[i].flg, tbl8[i].err}));
      end
      e8_in_valid = 0;

      // Random stream with random back-pressure, scored in order
      tick();
      sent = 0; got = 0; cyc = 0;
      while (got < NRAND && cyc < 30000) begin
         if (!in_valid && sent < NRAND && ($urandom % 4) != 0) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = (($urandom % 3) == 0) ? 32'($urandom % 40) : $urandom;
            in_valid = 1;
         end
         out_ready = (($urandom % 4) != 0);
         #1;
         acc = 0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rand_unexpected_result", 64'(result), 64'hDEAD);
            end else begin
               e = q.pop_front();
               chk($sformatf("rand[%0d]", got), 64'({result, flags, op_err}),
                   64'({e.res[31:0], e.flg, e.err}));
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(32, 1'b1, op, 64'(a), 64'(b)));
            sent++;
            acc = 1;
         end
         tick();
         if (acc) in_valid = 0;
         cyc++;
      end
      chk("rand_completed", 64'(got), 64'(NRAND));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_alu_seq_param
`default_nettype wire
